// File: rtl/spi_reg_ctrl.sv
// Byte-level command controller between an SPI slave byte engine and a register bank.
// Byte 0 of a frame is {write, auto_inc, addr}; subsequent bytes are write data or read data.
module spi_reg_ctrl #(
  parameter int          ADDR_W      = 6,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              spi_done,
  input  logic [7:0]        spi_dout,
  output logic [7:0]        spi_din,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_end
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t            state;
  logic              ss_m;
  logic              ss_s;
  logic              inc;
  logic              rd_pend;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic              unused_dout;

  // Address wraps modulo 2^ADDR_W; inc=0 keeps the frame on one register.
  assign addr_nxt    = addr + ADDR_W'(inc);
  assign busy        = (state != IDLE);
  assign unused_dout = ^spi_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ss_m      <= 1'b1;
      ss_s      <= 1'b1;
      inc       <= 1'b0;
      rd_pend   <= 1'b0;
      addr      <= '0;
      spi_din   <= STATUS_BYTE;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      ss_m      <= ss;
      ss_s      <= ss_m;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_end <= 1'b0;
      rd_pend   <= reg_re;

      // Read data arrives the cycle after reg_re; only an active read frame exposes it.
      if (rd_pend && state == RD)
        spi_din <= reg_rdata;

      case (state)
        IDLE: begin
          spi_din <= STATUS_BYTE;
          if (!ss_s)
            state <= CMD;
        end
        CMD: begin
          if (spi_done) begin
            addr <= spi_dout[ADDR_W-1:0];
            inc  <= spi_dout[6];
            if (spi_dout[7]) begin
              state <= WR;
            end else begin
              state    <= RD;
              reg_re   <= 1'b1;
              reg_addr <= spi_dout[ADDR_W-1:0];
            end
          end
        end
        WR: begin
          if (spi_done) begin
            reg_we    <= 1'b1;
            reg_addr  <= addr;
            reg_wdata <= spi_dout;
            addr      <= addr_nxt;
          end
        end
        RD: begin
          if (spi_done) begin
            reg_re   <= 1'b1;
            reg_addr <= addr_nxt;
            addr     <= addr_nxt;
          end
        end
        default: state <= IDLE;
      endcase

      // Chip select released: strobes scheduled above still issue, the frame ends here.
      if (state != IDLE && ss_s) begin
        state     <= IDLE;
        frame_end <= 1'b1;
        spi_din   <= STATUS_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: emulates the SPI byte engine and a register bank,
// and predicts strobes and MISO bytes from the command-byte rules.
module tb_spi_reg_ctrl;
  localparam int         AW = 6;
  localparam logic [7:0] ST = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ss;
  logic          spi_done;
  logic [7:0]    spi_dout;
  logic [7:0]    spi_din;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic          busy;
  logic          frame_end;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(AW), .STATUS_BYTE(ST)) dut (
    .clk(clk), .rst(rst), .ss(ss), .spi_done(spi_done), .spi_dout(spi_dout),
    .spi_din(spi_din), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .busy(busy), .frame_end(frame_end)
  );

  // Register bank seen by the DUT.
  logic [7:0] bank [64];
  always @(posedge clk) begin
    if (reg_we) bank[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bank[reg_addr];
  end

  logic [7:0]  ref_mem [64];
  logic [13:0] obs_wr_q[$];
  logic [13:0] exp_wr_q[$];
  logic [5:0]  obs_rd_q[$];
  logic [5:0]  exp_rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  miso_q[$];
  logic [7:0]  exp_q[$];
  int fe_cnt = 0;
  int both_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  initial forever begin
    @(negedge clk);
    if (reg_we) obs_wr_q.push_back({reg_addr, reg_wdata});
    if (reg_re) obs_rd_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
    if (frame_end) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_wr_q.delete();
    obs_rd_q.delete();
    fe_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic pulse_done(input logic [7:0] b);
    repeat ($urandom_range(10, 18)) @(posedge clk);
    #1 spi_dout = b;
    spi_done = 1'b1;
    @(posedge clk);
    #1 spi_done = 1'b0;
    spi_dout = 8'($urandom);
  endtask

  // Sends tx_q as one frame; partial adds an unfinished byte before ss rises.
  task automatic run_frame(input bit partial);
    miso_q.delete();
    @(posedge clk);
    #1 ss = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) miso_q.push_back(spi_din);
    for (int i = 0; i < tx_q.size(); i++) begin
      repeat ($urandom_range(10, 18)) @(posedge clk);
      #1 spi_dout = tx_q[i];
      spi_done = 1'b1;
      @(negedge clk);
      if (i < tx_q.size() - 1) miso_q.push_back(spi_din);
      @(posedge clk);
      #1 spi_done = 1'b0;
      spi_dout = 8'($urandom);
    end
    if (partial) repeat (6) @(posedge clk);
    #1 ss = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Reference model: derive strobes and MISO from the command byte, then compare.
  task automatic check_frame(input string tag);
    logic [7:0] cmd;
    int start, inc, n;
    logic [5:0] a;
    cmd   = tx_q[0];
    start = int'(cmd[5:0]);
    inc   = int'(cmd[6]);
    n     = tx_q.size() - 1;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_q.delete();
    if (cmd[7]) begin
      for (int i = 0; i < n; i++) begin
        a = 6'((start + i * inc) % 64);
        exp_wr_q.push_back({a, tx_q[i+1]});
        ref_mem[a] = tx_q[i+1];
      end
    end else begin
      for (int j = 0; j <= n; j++) exp_rd_q.push_back(6'((start + j * inc) % 64));
      for (int k = 0; k <= n; k++)
        exp_q.push_back(k < 2 ? ST : ref_mem[6'((start + (k - 2) * inc) % 64)]);
    end
    check({tag, " wr_count"}, 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
    for (int i = 0; i < exp_wr_q.size() && i < obs_wr_q.size(); i++)
      check({tag, " wr_addr_data"}, 32'(obs_wr_q[i]), 32'(exp_wr_q[i]));
    check({tag, " rd_count"}, 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
    for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++)
      check({tag, " rd_addr"}, 32'(obs_rd_q[i]), 32'(exp_rd_q[i]));
    if (!cmd[7])
      for (int k = 0; k < exp_q.size() && k < miso_q.size(); k++)
        check({tag, " miso"}, 32'(miso_q[k]), 32'(exp_q[k]));
    check({tag, " frame_end_count"}, 32'(fe_cnt), 32'd1);
    check({tag, " we_re_overlap"}, 32'(both_cnt), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " spi_din_after"}, 32'(spi_din), 32'(ST));
    clear_obs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " spi_din"}, 32'(spi_din), 32'(ST));
    check({tag, " reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, " reg_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, " reg_we"}, 32'(reg_we), 32'd0);
    check({tag, " reg_re"}, 32'(reg_re), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " frame_end"}, 32'(frame_end), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ss = 1'b1;
    spi_done = 1'b0;
    spi_dout = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear_obs();

    // Fill every register through one auto-increment burst.
    tx_q = {8'hC0};
    for (int i = 0; i < 64; i++) tx_q.push_back(8'($urandom));
    run_frame(1'b0);
    check_frame("fill");

    tx_q = {8'hC2, 8'h11, 8'h22, 8'h33};
    run_frame(1'b0);
    check_frame("write_burst");

    tx_q = {8'h85, 8'h5A};
    run_frame(1'b0);
    check_frame("write_reg5");
    tx_q = {8'h05, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    check_frame("read_noinc");

    tx_q = {8'hFF, 8'h01, 8'h02};
    run_frame(1'b0);
    check_frame("write_wrap");
    tx_q = {8'h7F, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    check_frame("read_wrap");

    tx_q = {8'hC8, 8'h77};
    run_frame(1'b1);
    check_frame("abort");

    // Reset in the middle of a read burst.
    @(posedge clk);
    #1 ss = 1'b0;
    repeat (8) @(posedge clk);
    pulse_done(8'h45);
    pulse_done(8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk) check_reset_outputs("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    ss = 1'b1;
    repeat (10) @(posedge clk);
    #1 clear_obs();
    tx_q = {8'h83, 8'h44};
    run_frame(1'b0);
    check_frame("after_rst");

    // spi_done while deselected must be ignored.
    for (int i = 0; i < 3; i++) begin
      pulse_done(8'h81);
      @(negedge clk) check("idle_done busy", 32'(busy), 32'd0);
    end
    repeat (4) @(posedge clk);
    check("idle_done wr_count", 32'(obs_wr_q.size()), 32'd0);
    check("idle_done rd_count", 32'(obs_rd_q.size()), 32'd0);
    check("idle_done frame_end", 32'(fe_cnt), 32'd0);
    #1 clear_obs();

    for (int r = 0; r < 8; r++) begin
      tx_q = {8'($urandom)};
      for (int i = $urandom_range(1, 4); i > 0; i--) tx_q.push_back(8'($urandom));
      run_frame(1'b0);
      check_frame("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
